// File: rtl/tone_pkg.sv
// Shared state type, widths and note-decode helpers for the tone mixer.
// Pure definitions: no logic, no latency.
package tone_pkg;

    localparam int CODE_W = 8;
    localparam int DIV_W  = 9;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    typedef logic [11:0][DIV_W-1:0] div_tbl_t;

    // Note-counter reload per semitone within an octave.
    function automatic div_tbl_t div_table();
        div_tbl_t t;
        t[0]  = 9'd511;
        t[1]  = 9'd482;
        t[2]  = 9'd455;
        t[3]  = 9'd430;
        t[4]  = 9'd405;
        t[5]  = 9'd383;
        t[6]  = 9'd361;
        t[7]  = 9'd341;
        t[8]  = 9'd322;
        t[9]  = 9'd303;
        t[10] = 9'd286;
        t[11] = 9'd270;
        return t;
    endfunction

    function automatic logic [7:0] oct_reload(input logic [2:0] octave);
        return 8'hFF >> octave;
    endfunction

endpackage

// File: rtl/tone_mixer_if.sv
// Per-channel note request bundle: valid/ready handshake with packed code and duration.
// Sequencer drives master; the mixer takes the slave side and owns note_ready.
interface tone_mixer_if
    import tone_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DUR_W  = 16
);
    logic [NUM_CH-1:0]        note_valid;
    logic [NUM_CH-1:0]        note_ready;
    logic [CODE_W*NUM_CH-1:0] note_code;
    logic [DUR_W*NUM_CH-1:0]  note_dur;

    modport master (
        output note_valid,
        output note_code,
        output note_dur,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_code,
        input  note_dur,
        output note_ready
    );
endinterface

// File: rtl/tone_channel.sv
// One tone voice: accepts a note, toggles a square wave for dur ticks; first toggle 1 clk after accept.
// Ready only in IDLE unless TONE_LEGATO_EN, which keeps ready high and retunes without a phase reset.
module tone_channel
    import tone_pkg::*;
#(
    parameter int DUR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CODE_W-1:0] code_i,
    input  logic [DUR_W-1:0]  dur_i,
    output logic              busy_o,
    output logic              wave_o
);

    localparam div_tbl_t DIV_TBL = div_table();

    state_e            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [DUR_W-1:0]  rem_q, rem_d;
    logic [DIV_W-1:0]  note_q, note_d;
    logic [7:0]        oct_q, oct_d;
    logic              wave_q, wave_d;

    logic [5:0]       idx;
    logic [2:0]       octave;
    logic [3:0]       semi;
    logic [DIV_W-1:0] div_val;
    logic [7:0]       oct_val;
    logic             accept;

    assign idx     = code_q[5:0];
    assign octave  = 3'(idx / 6'd12);
    assign semi    = 4'(idx % 6'd12);
    assign div_val = DIV_TBL[semi];
    assign oct_val = oct_reload(octave);

`ifdef TONE_LEGATO_EN
    assign ready_o = 1'b1;
`else
    assign ready_o = (state_q == IDLE);
`endif

    assign accept = valid_i && ready_o;
    assign busy_o = (state_q == PLAY);
    assign wave_o = wave_q;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        rem_d   = rem_q;
        note_d  = note_q;
        oct_d   = oct_q;
        wave_d  = wave_q;

        if (state_q == PLAY) begin
            note_d = (note_q == '0) ? div_val : note_q - 1'b1;
            if (note_q == '0) begin
                oct_d = (oct_q == '0) ? oct_val : oct_q - 1'b1;
            end
            if (note_q == '0 && oct_q == '0 && code_q != '0) begin
                wave_d = ~wave_q;
            end
            // Expiry wins over the pending toggle so the pin always rests low.
            if (tick_i) begin
                if (rem_q <= DUR_W'(1)) begin
                    state_d = IDLE;
                    rem_d   = '0;
                    wave_d  = 1'b0;
                end else begin
                    rem_d = rem_q - 1'b1;
                end
            end
        end

`ifdef TONE_LEGATO_EN
        if (accept) begin
            code_d = code_i;
            rem_d  = dur_i;
            if (dur_i == '0) begin
                state_d = IDLE;
                wave_d  = 1'b0;
            end else begin
                state_d = PLAY;
                if (state_q == IDLE) begin
                    note_d = '0;
                    oct_d  = '0;
                end
                if (code_i == '0) begin
                    wave_d = 1'b0;
                end
            end
        end
`else
        if (accept && dur_i != '0) begin
            state_d = PLAY;
            code_d  = code_i;
            rem_d   = dur_i;
            note_d  = '0;
            oct_d   = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            rem_q   <= '0;
            note_q  <= '0;
            oct_q   <= '0;
            wave_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            rem_q   <= rem_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
            wave_q  <= wave_d;
        end
    end

endmodule

// File: rtl/tone_mixer.sv
// NUM_CH tone channels sharing a duration-tick prescaler, mixed to one pin by a first-order sigma-delta.
// Speaker lags the channel waves by one clk; per-channel backpressure via note_ready (TONE_LEGATO_EN keeps it high).
module tone_mixer
    import tone_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int DUR_W    = 16,
    parameter int TICK_DIV = 25000
) (
    input  logic              clk,
    input  logic              rst,
    tone_mixer_if.slave       note_if,
    output logic [NUM_CH-1:0] ch_busy,
    output logic [NUM_CH-1:0] ch_wave,
    output logic              speaker
);

    localparam int PS_W  = $clog2(TICK_DIV);
    localparam int ACC_W = $clog2(2 * NUM_CH + 1);

    logic [PS_W-1:0]  presc_q, presc_d;
    logic             tick;
    logic [ACC_W-1:0] acc_q, acc_d, acc_next, sum;
    logic             spk_q, spk_d;

    assign tick    = (presc_q == PS_W'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tone_channel #(
            .DUR_W (DUR_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick_i  (tick),
            .valid_i (note_if.note_valid[i]),
            .ready_o (note_if.note_ready[i]),
            .code_i  (note_if.note_code[CODE_W*i +: CODE_W]),
            .dur_i   (note_if.note_dur[DUR_W*i +: DUR_W]),
            .busy_o  (ch_busy[i]),
            .wave_o  (ch_wave[i])
        );
    end

    // acc stays below NUM_CH, so acc + sum never exceeds 2*NUM_CH-1.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = sum + ACC_W'(ch_wave[i]);
        end
        acc_next = acc_q + sum;
        spk_d    = (acc_next >= ACC_W'(NUM_CH));
        acc_d    = spk_d ? acc_next - ACC_W'(NUM_CH) : acc_next;
    end

    assign speaker = spk_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            acc_q   <= '0;
            spk_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            acc_q   <= acc_d;
            spk_q   <= spk_d;
        end
    end

endmodule

// File: doc/tone_mixer.md
Name: tone_mixer

Overview:
- Polyphonic successor to the single-voice square-wave note player.
- NUM_CH independent tone channels. Each channel accepts a note code plus a duration through a valid/ready handshake, and plays a square wave for that many duration ticks.
- Channel waves are mixed by a first-order sigma-delta modulator onto a single 1-bit speaker pin.
- Sits between the game sound sequencer and the board speaker pin.

Parameters:
- NUM_CH, 3, number of tone channels (1..8).
- DUR_W, 16, width of per-note duration in ticks.
- TICK_DIV, 25000, clk cycles per duration tick (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- note_valid  in  NUM_CH  per-channel request strobe.
- note_ready  out  NUM_CH  per-channel ready.
- note_code  in  8*NUM_CH  channel i at [8i+7:8i]. Value 0 = rest. Otherwise the semitone index is bits [5:0]; bits [7:6] are ignored.
- note_dur  in  DUR_W*NUM_CH  channel i duration in ticks.
- ch_busy  out  NUM_CH  1 while the channel is in PLAY.
- ch_wave  out  NUM_CH  per-channel square wave, registered.
- speaker  out  1  mixed PDM output, registered.

Behaviour:
- Reset: clk and rst only; reset is synchronous active-high. On reset, all channels go to IDLE, all counters clear, ch_wave=0, speaker=0, sigma-delta accumulator=0, tick prescaler=0. After rst deasserts, note_ready=all ones and ch_busy=0. Reset mid-note aborts the note immediately.
- Tick: the prescaler counts 0..TICK_DIV-1 and is free-running. A one-cycle tick pulse fires when it wraps.
- Note decode:
  - octave = code[5:0]/12 (0..5); semi = code[5:0]%12.
  - Divider reload (semi 0..11): 511, 482, 455, 430, 405, 383, 361, 341, 322, 303, 286, 270.
  - Octave reload: 255 >> octave (octave 0 -> 255, ..., octave 5 -> 7).
- Channel FSM, IDLE:
  - note_ready=1.
  - On valid&&ready, latch code and dur, clear the note and octave counters to 0, and go to PLAY.
  - dur=0: stay IDLE; handshake completes, no toggle.
- Channel FSM, PLAY:
  - Note counter decrements every clk and reloads the divider value at 0.
  - Octave counter decrements when the note counter is 0 and reloads at 0.
  - ch_wave toggles when both counters are 0 and code!=0. The first toggle is the edge after acceptance.
  - Half period = (div+1)*(oct_reload+1) clk.
  - Each tick decrements remaining. When remaining reaches 0, go to IDLE, force ch_wave=0, and raise note_ready the next cycle.
  - A rest (code 0) holds ch_wave=0 for its full duration.
- Tick on the same cycle as acceptance: the tick is not counted against the new note.
- Mixer:
  - sum = popcount(ch_wave).
  - Each clk: acc_next = acc + sum. If acc_next >= NUM_CH, speaker<=1 and acc<=acc_next-NUM_CH; else speaker<=0 and acc<=acc_next.
  - Long-run speaker duty = sum/NUM_CH.
  - acc width = clog2(2*NUM_CH+1).

Optional Feature:
- Macro: TONE_LEGATO_EN.
- Defined:
  - note_ready stays 1 in PLAY.
  - A new accept replaces code and dur, and remaining restarts.
  - ch_wave phase and counters are NOT cleared; the new divider takes effect at the next reload.
  - Accept on the same cycle as expiry: the new note wins and the channel stays in PLAY.
- Undefined: note_ready=0 throughout PLAY, as described above.

Decomposition:
- Package tone_pkg holds:
  - state enum {IDLE, PLAY};
  - a function returning the 12-entry divider table;
  - a function returning the octave reload;
  - constants CODE_W=8 and DIV_W=9.
- Sub-module tone_channel (FSM, counters, wave) is instantiated NUM_CH times via generate.
- Prescaler and mixer live in the top.

Test Plan:
- Reset: assert rst for 3 cycles mid-note -> ch_wave=0, speaker=0, note_ready all ones, ch_busy=0 on the first cycle after release.
- Tone period: TICK_DIV=4, ch0 code=12, dur=100000 -> ch_wave[0] first rises 1 clk after accept, then toggles every 65536 clk. Code=60 -> toggles every 512*8=4096 clk.
- Duration: TICK_DIV=4, code=61, dur=3 -> ch_busy high about 12 clk (3 ticks ±1 tick alignment), ch_wave forced 0 at exit, note_ready high the next cycle. dur=0 -> no busy, no toggle.
- Rest: code=0, dur=5 -> ch_busy high for 5 ticks, ch_wave constant 0.
- Mixer, NUM_CH=3: force 2 channels high (long notes, sample during high phase) -> speaker duty 2/3 over 3-clk windows. All 3 high -> speaker constantly 1. None high -> 0.
- Handshake: valid held during PLAY -> ready=0 and no re-accept (TONE_LEGATO_EN undefined). With it defined -> accept mid-note, remaining restarts, wave continues without phase glitch.
